// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if
//
// Bundle between the control unit and the multiply/divide sequencer.
//
// Request side (driven by the control unit / master):
//   start      - request a new MULT or DIV operation
//   op         - 0 = MULT, 1 = DIV, meaningful together with start
//   divisor    - B operand, examined for zero when a DIV is accepted
//   abort      - cancel the operation in flight (exception path)
//
// Status / control side (driven by the sequencer / slave):
//   mult_ctrl  - one-cycle start pulse to the multiplier
//   div_ctrl   - one-cycle start pulse to the divider
//   hi_src     - HI source select, 0 = multiplier, 1 = divider
//   lo_src     - LO source select, 0 = multiplier, 1 = divider
//   hilo_write - one-cycle HI/LO load enable
//   busy       - an operation is in flight
//   done       - one-cycle completion pulse
//   div_zero   - one-cycle divide-by-zero pulse
interface muldiv_sequencer_if;
    logic        start;
    logic        op;
    logic [31:0] divisor;
    logic        abort;
    logic        mult_ctrl;
    logic        div_ctrl;
    logic        hi_src;
    logic        lo_src;
    logic        hilo_write;
    logic        busy;
    logic        done;
    logic        div_zero;

    // The control unit issues requests and observes status.
    modport master (
        output start, op, divisor, abort,
        input  mult_ctrl, div_ctrl, hi_src, lo_src, hilo_write, busy, done, div_zero
    );

    // The sequencer consumes requests and produces status and unit controls.
    modport slave (
        input  start, op, divisor, abort,
        output mult_ctrl, div_ctrl, hi_src, lo_src, hilo_write, busy, done, div_zero
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//
// Sequences one multiply or divide at a time on the shared mult/div
// resource: accepts a request, pulses the matching unit's start, waits out
// the unit latency, then commits the result into HI/LO. A DIV with a zero
// divisor is trapped before any unit is launched. An abort from the
// exception path drops the operation and suppresses the HI/LO write.
//
// Parameters:
//   MULT_CYCLES - multiplier latency after its start pulse (>= 1)
//   DIV_CYCLES  - divider latency after its start pulse (>= 1)
//
// Ports:
//   clk   - single clock, all state changes on the rising edge
//   reset - synchronous, active-high
//   bus   - request/status bundle (slave side), see muldiv_sequencer_if
module muldiv_sequencer #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    muldiv_sequencer_if.slave    bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        RUN,
        WRITE,
        ZERO
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             op_q, op_d;

    // State register. Reset returns to IDLE with the counter cleared and the
    // latched op back at MULT, so every output decodes to 0 the next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            op_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
        end
    end

    // Next-state logic. A request is only taken in IDLE, and an abort in the
    // same cycle blocks it. The counter is loaded with latency-1 on
    // acceptance because RUN also spends the cycle in which it reads zero,
    // giving exactly N RUN cycles. LAUNCH does not count down. An abort from
    // any busy state drops straight back to IDLE; the counter is left as is
    // since it is always reloaded on the next acceptance.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        op_d    = op_q;
        case (state_q)
            IDLE: begin
                if (!bus.abort && bus.start) begin
                    op_d = bus.op;
                    if (bus.op && (bus.divisor == '0)) begin
                        state_d = ZERO;
                    end else begin
                        state_d = LAUNCH;
                        count_d = bus.op ? DIV_LOAD : MULT_LOAD;
                    end
                end
            end
            LAUNCH: begin
                state_d = bus.abort ? IDLE : RUN;
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (count_q == '0) begin
                    state_d = WRITE;
                end else begin
                    count_d = count_q - CNT_ONE;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            ZERO: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode. Everything comes from state and the latched op; the only
    // input that reaches an output is abort, which must be able to kill the
    // HI/LO write and done in the very cycle it is raised. The unit start
    // pulse in LAUNCH is deliberately not gated: the unit runs, and its
    // result is simply never committed.
    always_comb begin
        bus.mult_ctrl  = 1'b0;
        bus.div_ctrl   = 1'b0;
        bus.hilo_write = 1'b0;
        bus.done       = 1'b0;
        bus.div_zero   = 1'b0;
        bus.busy       = 1'b0;
        bus.hi_src     = op_q;
        bus.lo_src     = op_q;
        case (state_q)
            LAUNCH: begin
                bus.mult_ctrl = !op_q;
                bus.div_ctrl  = op_q;
                bus.busy      = 1'b1;
            end
            RUN: begin
                bus.busy = 1'b1;
            end
            WRITE: begin
                bus.hilo_write = !bus.abort;
                bus.done       = !bus.abort;
                bus.busy       = 1'b1;
            end
            ZERO: begin
                bus.div_zero = 1'b1;
            end
            default: begin
                bus.busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
//
// Bench for muldiv_sequencer. Two instances: dut_a with the default 32/32
// latencies and dut_b with MULT_CYCLES=1, DIV_CYCLES=3. Each request comes
// from a table row holding the request, any abort/reset/extra-start cycles,
// and the hand-derived cycle numbers (relative to the request cycle) at
// which the unit start pulse, the divide-by-zero pulse and the HI/LO write
// must appear, plus the cycle the sequencer is idle again.
// When a row is driven, its expected pulses go into a scoreboard queue; a
// monitor pops and compares them whenever the DUT produces a pulse.
module tb_muldiv_sequencer;

    localparam int K_MCTRL = 0;
    localparam int K_DCTRL = 1;
    localparam int K_WRITE = 2;
    localparam int K_ZERO  = 3;
    localparam int NVEC    = 14;

    typedef struct {
        string       name;
        int          dut;
        logic        op;
        logic [31:0] divisor;
        int          abort_at;
        int          reset_at;
        int          spur1;
        int          spur2;
        int          exp_ctrl;
        int          exp_zero;
        int          exp_write;
        int          exp_idle;
    } vec_t;

    typedef struct {
        int   dut;
        int   kind;
        int   cycle;
        logic src;
    } exp_t;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   cyc;
    int   vectors;
    int   miscompares;
    exp_t exp_q[$];
    vec_t vecs[NVEC];

    muldiv_sequencer_if bus_a();
    muldiv_sequencer_if bus_b();

    muldiv_sequencer #(.MULT_CYCLES(32), .DIV_CYCLES(32)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a)
    );

    muldiv_sequencer #(.MULT_CYCLES(1), .DIV_CYCLES(3)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b)
    );

    // Free-running clock and a cycle stamp that advances on every rising edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic logic [7:0] readOutputs(input int dut);
        if (dut == 0)
            return {bus_a.mult_ctrl, bus_a.div_ctrl, bus_a.hi_src, bus_a.lo_src,
                    bus_a.hilo_write, bus_a.busy, bus_a.done, bus_a.div_zero};
        return {bus_b.mult_ctrl, bus_b.div_ctrl, bus_b.hi_src, bus_b.lo_src,
                bus_b.hilo_write, bus_b.busy, bus_b.done, bus_b.div_zero};
    endfunction

    task automatic checkAllZero(input int dut, input string tag);
        logic [7:0] outs;
        string      names[8];
        names = '{"div_zero", "done", "busy", "hilo_write", "lo_src", "hi_src", "div_ctrl", "mult_ctrl"};
        outs = readOutputs(dut);
        for (int b = 0; b < 8; b++) begin
            checkOutput($sformatf("%s dut%0d %s", tag, dut, names[b]), int'(outs[b]), 0);
        end
    endtask

    task automatic driveInputs(input int dut, input logic start, input logic op,
                               input logic [31:0] divisor, input logic abort, input logic rst);
        bus_a.start   = (dut == 0) ? start : 1'b0;
        bus_a.op      = (dut == 0) ? op : 1'b0;
        bus_a.divisor = (dut == 0) ? divisor : 32'd0;
        bus_a.abort   = (dut == 0) ? abort : 1'b0;
        rst_a         = (dut == 0) ? rst : 1'b0;
        bus_b.start   = (dut == 1) ? start : 1'b0;
        bus_b.op      = (dut == 1) ? op : 1'b0;
        bus_b.divisor = (dut == 1) ? divisor : 32'd0;
        bus_b.abort   = (dut == 1) ? abort : 1'b0;
        rst_b         = (dut == 1) ? rst : 1'b0;
    endtask

    // Drive one table row cycle by cycle. Cycle 0 is the request cycle; the
    // expected pulses are queued then. busy must be high from the launch
    // cycle up to the cycle before the sequencer is idle again, and low
    // throughout for requests that never launch a unit.
    task automatic applyStimulus(input vec_t v);
        int   c0;
        int   n_cycles;
        logic start;
        logic [7:0] outs;
        c0 = 0;
        n_cycles = (v.exp_idle > 0) ? v.exp_idle : 3;
        for (int k = 0; k < n_cycles; k++) begin
            @(negedge clk);
            if (k == 0) begin
                c0 = cyc;
                if (v.exp_ctrl > 0)
                    exp_q.push_back('{v.dut, v.op ? K_DCTRL : K_MCTRL, c0 + v.exp_ctrl, v.op});
                if (v.exp_zero > 0)
                    exp_q.push_back('{v.dut, K_ZERO, c0 + v.exp_zero, v.op});
                if (v.exp_write > 0)
                    exp_q.push_back('{v.dut, K_WRITE, c0 + v.exp_write, v.op});
            end
            start = (k == 0) || (k == v.spur1) || (k == v.spur2);
            if (k == 0)
                driveInputs(v.dut, start, v.op, v.divisor, k == v.abort_at, k == v.reset_at);
            else
                driveInputs(v.dut, start, 1'b1, 32'd0, k == v.abort_at, k == v.reset_at);
            #2;
            outs = readOutputs(v.dut);
            checkOutput($sformatf("%s busy k=%0d", v.name, k), int'(outs[2]),
                        (v.exp_ctrl > 0 && k >= 1) ? 1 : 0);
        end
        if (v.reset_at >= 0) begin
            @(negedge clk);
            driveInputs(v.dut, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
            #2;
            checkAllZero(v.dut, {v.name, " after reset"});
        end
    endtask

    // Match one observed pulse against the oldest outstanding expectation.
    task automatic handleEvent(input int dut, input int kind, input logic hi, input logic lo);
        exp_t e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_pulse: got dut%0d kind %0d at cycle %0d, expected none",
                     dut, kind, cyc);
        end else begin
            e = exp_q.pop_front();
            checkOutput("pulse dut", dut, e.dut);
            checkOutput("pulse kind", kind, e.kind);
            checkOutput("pulse cycle", cyc, e.cycle);
            checkOutput("pulse hi_src", int'(hi), int'(e.src));
            checkOutput("pulse lo_src", int'(lo), int'(e.src));
        end
    endtask

    task automatic monitorDut(input int dut);
        logic [7:0] o;
        o = readOutputs(dut);
        if ($countones({o[7], o[6], o[3], o[0]}) > 1)
            checkOutput($sformatf("dut%0d exclusive pulses", dut),
                        $countones({o[7], o[6], o[3], o[0]}), 1);
        if (o[1] != o[3])
            checkOutput($sformatf("dut%0d done with hilo_write", dut), int'(o[1]), int'(o[3]));
        if (o[7]) handleEvent(dut, K_MCTRL, o[5], o[4]);
        if (o[6]) handleEvent(dut, K_DCTRL, o[5], o[4]);
        if (o[3]) handleEvent(dut, K_WRITE, o[5], o[4]);
        if (o[0]) handleEvent(dut, K_ZERO, o[5], o[4]);
    endtask

    // Pulse monitor, sampling mid-cycle once the inputs for the cycle settled.
    always @(negedge clk) begin
        #2;
        monitorDut(0);
        monitorDut(1);
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        // name, dut, op, divisor, abort_at, reset_at, spur1, spur2,
        // exp_ctrl, exp_zero, exp_write, exp_idle
        vecs[0]  = '{"mult_basic",     0, 1'b0, 32'd0,          -1, -1, -1, -1, 1, -1, 34, 35};
        vecs[1]  = '{"div_by_7",       0, 1'b1, 32'd7,          -1, -1, -1, -1, 1, -1, 34, 35};
        vecs[2]  = '{"mult_b2b",       0, 1'b0, 32'd7,          -1, -1, -1, -1, 1, -1, 34, 35};
        vecs[3]  = '{"div_by_zero",    0, 1'b1, 32'd0,          -1, -1, -1, -1, -1, 1, -1, 2};
        vecs[4]  = '{"mult_abort10",   0, 1'b0, 32'd3,          10, -1, -1, -1, 1, -1, -1, 11};
        vecs[5]  = '{"mult_spurious",  0, 1'b0, 32'd0,          -1, -1,  5, 20, 1, -1, 34, 35};
        vecs[6]  = '{"div_reset15",    0, 1'b1, 32'd5,          -1, 15, -1, -1, 1, -1, -1, 16};
        vecs[7]  = '{"div_abort_wr",   0, 1'b1, 32'hFFFF_FFFF,  34, -1, -1, -1, 1, -1, -1, 35};
        vecs[8]  = '{"mult_abort_la",  0, 1'b0, 32'd0,           1, -1, -1, -1, 1, -1, -1, 2};
        vecs[9]  = '{"b_mult",         1, 1'b0, 32'd0,          -1, -1, -1, -1, 1, -1, 3, 4};
        vecs[10] = '{"b_div",          1, 1'b1, 32'd3,          -1, -1, -1, -1, 1, -1, 5, 6};
        vecs[11] = '{"b_start_abort",  1, 1'b1, 32'd9,           0, -1, -1, -1, -1, -1, -1, 0};
        vecs[12] = '{"b_mult_after",   1, 1'b0, 32'd1,          -1, -1, -1, -1, 1, -1, 3, 4};
        vecs[13] = '{"b_div_zero",     1, 1'b1, 32'd0,          -1, -1, -1, -1, -1, 1, -1, 2};

        driveInputs(0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        checkAllZero(0, "reset");
        checkAllZero(1, "reset");
        @(negedge clk);
        driveInputs(0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
        end

        @(negedge clk);
        driveInputs(0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        #2;
        checkOutput("outstanding expected pulses", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Sequencer for the shared multiply/divide resource: accepts one MULT or DIV request at a time from the control unit, launches the matching multi-cycle unit, counts its latency, then commits its result into HI/LO. Sits between the control unit and the mult/div units, the HI/LO source muxes and the HI/LO write enable. Detects divide-by-zero before launching, and supports abort on exception.

## Interface
- MULT_CYCLES, 32, cycles the mult unit needs after its start pulse (≥1)
- DIV_CYCLES, 32, cycles the div unit needs after its start pulse (≥1)

- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only in IDLE
- op  in  1  0 = MULT, 1 = DIV; sampled with start
- divisor  in  32  B operand; checked for zero when a DIV is accepted
- abort  in  1  cancel the running operation (exception path)
- mult_ctrl  out  1  one-cycle start pulse to mult unit
- div_ctrl  out  1  one-cycle start pulse to div unit
- hi_src  out  1  HI mux select: 0 mult, 1 div
- lo_src  out  1  LO mux select: 0 mult, 1 div
- hilo_write  out  1  HI/LO load enable, one-cycle pulse
- busy  out  1  operation in flight
- done  out  1  one-cycle completion pulse
- div_zero  out  1  one-cycle divide-by-zero pulse

## Operation
- States: IDLE, LAUNCH, RUN, WRITE, ZERO.
- IDLE: if abort=1, stay (start ignored). Else if start=1: latch op; if op=1 and divisor==0 → ZERO; else → LAUNCH, load counter with (op ? DIV_CYCLES : MULT_CYCLES)−1.
- ZERO: div_zero=1 for this cycle only; → IDLE. No unit launched, no HI/LO write.
- LAUNCH: mult_ctrl=1 if latched op=0, else div_ctrl=1; → RUN.
- RUN: counter decrements each cycle; when counter==0 → WRITE.
- WRITE: hilo_write=1, done=1; → IDLE.
- abort=1 in LAUNCH, RUN or WRITE: → IDLE next edge; in that cycle hilo_write and done are forced 0; ctrl pulse in LAUNCH still issued (unit result discarded).
- hi_src = lo_src = latched op; updated on acceptance, held through WRITE, retain value in IDLE.
- busy=1 in LAUNCH, RUN, WRITE; 0 in IDLE and ZERO.
- start while busy: ignored, not queued.
- Counter width: clog2(max(MULT_CYCLES, DIV_CYCLES))+1 bits; no wrap; reloaded only on acceptance.

## Timing
- Reset (any state, incl. mid-RUN): state=IDLE, counter=0, latched op=0; all outputs 0 next cycle.
- Request accepted at edge of cycle 0 → LAUNCH in cycle 1 → RUN cycles 2..N+1 (N = cycle count) → WRITE cycle N+2 → IDLE cycle N+3, new start acceptable there.
- Default MULT: start cycle 0, mult_ctrl cycle 1, hilo_write/done cycle 34.
- DIV by zero: start cycle 0, div_zero cycle 1, IDLE cycle 2; busy never asserted.
- hi_src/lo_src valid from cycle 1 and stable through the hilo_write cycle.
- All outputs registered or decoded from state only; no combinational path from start/op/divisor to outputs.
- Exactly one of mult_ctrl, div_ctrl, hilo_write, div_zero may be 1 in any cycle.

## Test plan
- Reset, then MULT (start=1, op=0, 1 cycle) → mult_ctrl at cycle 1, busy cycles 1–34, hilo_write=done=1 at cycle 34 only, hi_src=lo_src=0.
- DIV, divisor=7 → div_ctrl at cycle 1, hilo_write at cycle 34, hi_src=lo_src=1; MULT issued at cycle 35 accepted, select returns to 0 at cycle 36.
- DIV, divisor=0 → div_zero=1 at cycle 1 only, no div_ctrl, no hilo_write, busy stays 0.
- MULT, abort=1 at cycle 10 → IDLE at cycle 11, no hilo_write/done ever; start at cycle 11 accepted.
- start pulses at cycles 5 and 20 during a running MULT → ignored; single hilo_write at cycle 34; reset at cycle 15 of another run → all outputs 0 at cycle 16, no write.
- MULT_CYCLES=1, DIV_CYCLES=3 → MULT write at cycle 3, DIV write at cycle 5; start and abort together in IDLE → not accepted.
